// File: rtl/spi_snapshot_ctrl_if.sv
// rtl/spi_snapshot_ctrl_if.sv - SPI byte-read bus and snapshot RAM port bundle
// slave = snapshot controller, master = SPI byte engine plus RAM side.
interface spi_snapshot_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              rd_req_i;
  logic [7:0]        rd_addr_i;
  logic [7:0]        rd_data_o;
  logic              rd_valid_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_wdata_o;
  logic [7:0]        ram_rdata_i;

  modport slave (
    input  rd_req_i, rd_addr_i, ram_rdata_i,
    output rd_data_o, rd_valid_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output rd_req_i, rd_addr_i, ram_rdata_i,
    input  rd_data_o, rd_valid_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/spi_snapshot_ctrl.sv
// rtl/spi_snapshot_ctrl.sv - double-banked key snapshot sequencer with SPI read arbitration
// Captures keys, writes them into the back bank, swaps banks only while SPI CS is idle.
module spi_snapshot_ctrl #(
  parameter int NUM_KEYS = 61,
  parameter int ADDR_W   = 9
) (
  input  logic                clk_g_i,
  input  logic                rst_g_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  input  logic                spi_cs_g_i,
  spi_snapshot_ctrl_if.slave  bus,
  output logic                bank_o,
  output logic [7:0]          snap_id_o,
  output logic                swap_o
);

  localparam int         GROUPS   = (NUM_KEYS + 7) / 8;
  localparam int         CAP_W    = GROUPS * 8;
  localparam logic [7:0] LAST_G   = 8'(GROUPS - 1);
  localparam logic [8:0] GROUPS_9 = 9'(GROUPS);

  typedef enum logic [1:0] {CAPTURE, SCAN, WAIT_SWAP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         g_q, g_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic               bank_q, bank_d;
  logic               fv_q, fv_d;
  logic [7:0]         snap_q, snap_d;
  logic               rv_q, rv_d;
  logic               rsrc_q, rsrc_d;
  logic [7:0]         rimm_q, rimm_d;
  logic [7:0]         rhold_q, rhold_d;

  logic               rd_hit;
  logic               wr_en;
  logic               do_swap;
  logic [7:0]         wr_byte;
  logic [7:0]         rd_data;

  // A read only owns the RAM port when it targets a valid front-bank group.
  always_comb begin
    rd_hit  = bus.rd_req_i && ({1'b0, bus.rd_addr_i} < GROUPS_9) && fv_q;
    wr_en   = (state_q == SCAN) && !rd_hit;
    do_swap = (state_q == WAIT_SWAP) && spi_cs_g_i;
    wr_byte = 8'(cap_q >> {g_q, 3'b000});
    rd_data = rv_q ? (rsrc_q ? bus.ram_rdata_i : rimm_q) : rhold_q;
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cap_d   = cap_q;
    bank_d  = bank_q;
    fv_d    = fv_q;
    snap_d  = snap_q;
    case (state_q)
      CAPTURE: begin
        cap_d   = CAP_W'(keys_i);
        g_d     = 8'h00;
        state_d = SCAN;
      end
      SCAN: begin
        if (wr_en) begin
          g_d = g_q + 8'h01;
          if (g_q == LAST_G) state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (do_swap) begin
          bank_d  = ~bank_q;
          fv_d    = 1'b1;
          snap_d  = snap_q + 8'h01;
          state_d = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
    // Non-RAM responses are decided at request time, so 0xFF reports the pre-swap id.
    rv_d    = bus.rd_req_i;
    rsrc_d  = rd_hit;
    rimm_d  = (bus.rd_addr_i == 8'hFF) ? snap_q : 8'h00;
    rhold_d = rd_data;
  end

  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      state_q <= CAPTURE;
      g_q     <= 8'h00;
      cap_q   <= '0;
      bank_q  <= 1'b0;
      fv_q    <= 1'b0;
      snap_q  <= 8'h00;
      rv_q    <= 1'b0;
      rsrc_q  <= 1'b0;
      rimm_q  <= 8'h00;
      rhold_q <= 8'h00;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cap_q   <= cap_d;
      bank_q  <= bank_d;
      fv_q    <= fv_d;
      snap_q  <= snap_d;
      rv_q    <= rv_d;
      rsrc_q  <= rsrc_d;
      rimm_q  <= rimm_d;
      rhold_q <= rhold_d;
    end
  end

  assign bus.ram_we_o    = wr_en;
  assign bus.ram_addr_o  = rd_hit ? ADDR_W'({bank_q, bus.rd_addr_i}) :
                           wr_en  ? ADDR_W'({~bank_q, g_q}) : '0;
  assign bus.ram_wdata_o = wr_en ? wr_byte : 8'h00;
  assign bus.rd_valid_o  = rv_q;
  assign bus.rd_data_o   = rd_data;
  assign bank_o          = bank_q;
  assign snap_id_o       = snap_q;
  assign swap_o          = do_swap;

endmodule

// File: tb/tb_spi_snapshot_ctrl.sv
// tb/tb_spi_snapshot_ctrl.sv - vector table, directed corners and random model check of spi_snapshot_ctrl
module tb_spi_snapshot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [60:0] keys = '0;
  logic        cs = 1'b1;
  logic        bank;
  logic [7:0]  snap;
  logic        swap;

  spi_snapshot_ctrl_if #(.ADDR_W(9)) bus ();

  spi_snapshot_ctrl #(.NUM_KEYS(61), .ADDR_W(9)) dut (
    .clk_g_i    (clk),
    .rst_g_i    (rst),
    .keys_i     (keys),
    .spi_cs_g_i (cs),
    .bus        (bus),
    .bank_o     (bank),
    .snap_id_o  (snap),
    .swap_o     (swap)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [60:0] keys;
    logic        cs;
    logic        req;
    logic [7:0]  raddr;
    logic        we;
    logic        chk_addr;
    logic [8:0]  addr;
    logic [7:0]  wdata;
    logic        swap;
    logic        bank;
    logic [7:0]  snap;
    logic        rv;
    logic [7:0]  rdata;
  } vec_t;

  function automatic vec_t mk(input logic [60:0] k, input logic c, input logic rq, input logic [7:0] ra,
                              input logic w, input logic ca, input logic [8:0] a, input logic [7:0] wd,
                              input logic sw, input logic b, input logic [7:0] sn, input logic v,
                              input logic [7:0] rd);
    vec_t t;
    t.keys = k; t.cs = c; t.req = rq; t.raddr = ra; t.we = w; t.chk_addr = ca; t.addr = a;
    t.wdata = wd; t.swap = sw; t.bank = b; t.snap = sn; t.rv = v; t.rdata = rd;
    return t;
  endfunction

  // random-phase reference state: sweep progress as counters, snapshots as 64-bit byte vectors
  logic        m_cap, m_fv, m_bank, m_rv;
  int          m_left;
  logic [7:0]  m_snapid, m_rd;
  logic [63:0] m_snap, m_front;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[22];
    logic [60:0] k1, k2, g, ones;
    logic        hit, exp_we, exp_swap;
    int          nsw, cyc, r;
    k1   = 61'h1;
    k2   = 61'h1ABC_DEF0_1234_5678;
    g    = 61'h0555_5555_5555_5555;
    ones = '1;

    // period 1..10: first sweep (read before front valid, 0xFF read); 11..22: stalled second sweep
    tbl[0]  = mk(k1, 1, 0, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[1]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h100, 8'h01, 0, 0, 8'd0, 0, 8'h00);
    tbl[2]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h101, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[3]  = mk(k1, 1, 1, 8'h00, 1, 1, 9'h102, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[4]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h103, 8'h00, 0, 0, 8'd0, 1, 8'h00);
    tbl[5]  = mk(k1, 1, 1, 8'hFF, 1, 1, 9'h104, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[6]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h105, 8'h00, 0, 0, 8'd0, 1, 8'h00);
    tbl[7]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h106, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[8]  = mk(k1, 1, 0, 8'h00, 1, 1, 9'h107, 8'h00, 0, 0, 8'd0, 0, 8'h00);
    tbl[9]  = mk(k1, 1, 0, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0, 8'd0, 0, 8'h00);
    tbl[10] = mk(k2, 1, 0, 8'h00, 0, 0, 9'h000, 8'h00, 0, 1, 8'd1, 0, 8'h00);
    tbl[11] = mk(g,  1, 0, 8'h00, 1, 1, 9'h000, 8'h78, 0, 1, 8'd1, 0, 8'h00);
    tbl[12] = mk(g,  1, 0, 8'h00, 1, 1, 9'h001, 8'h56, 0, 1, 8'd1, 0, 8'h00);
    tbl[13] = mk(g,  1, 0, 8'h00, 1, 1, 9'h002, 8'h34, 0, 1, 8'd1, 0, 8'h00);
    tbl[14] = mk(g,  1, 1, 8'h03, 0, 1, 9'h103, 8'h00, 0, 1, 8'd1, 0, 8'h00);
    tbl[15] = mk(g,  1, 0, 8'h00, 1, 1, 9'h003, 8'h12, 0, 1, 8'd1, 1, 8'h00);
    tbl[16] = mk(g,  1, 0, 8'h00, 1, 1, 9'h004, 8'hF0, 0, 1, 8'd1, 0, 8'h00);
    tbl[17] = mk(g,  1, 0, 8'h00, 1, 1, 9'h005, 8'hDE, 0, 1, 8'd1, 0, 8'h00);
    tbl[18] = mk(g,  1, 0, 8'h00, 1, 1, 9'h006, 8'hBC, 0, 1, 8'd1, 0, 8'h00);
    tbl[19] = mk(g,  1, 0, 8'h00, 1, 1, 9'h007, 8'h1A, 0, 1, 8'd1, 0, 8'h00);
    tbl[20] = mk(g,  1, 0, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 8'd1, 0, 8'h00);
    tbl[21] = mk(ones, 0, 0, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 8'd2, 0, 8'h00);

    bus.rd_req_i  = 1'b0;
    bus.rd_addr_i = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("reset_we", bus.ram_we_o, 0);
      chk("reset_addr", bus.ram_addr_o, 0);
      chk("reset_wdata", bus.ram_wdata_o, 0);
      chk("reset_rv", bus.rd_valid_o, 0);
      chk("reset_rdata", bus.rd_data_o, 0);
      chk("reset_swap", swap, 0);
      chk("reset_bank", bank, 0);
      chk("reset_snap", snap, 0);
    end

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = 1'b0;
      keys = tbl[i].keys; cs = tbl[i].cs;
      bus.rd_req_i = tbl[i].req; bus.rd_addr_i = tbl[i].raddr;
      #1;
      chk($sformatf("tbl%0d_we", i), bus.ram_we_o, tbl[i].we);
      if (tbl[i].chk_addr) chk($sformatf("tbl%0d_addr", i), bus.ram_addr_o, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("tbl%0d_wdata", i), bus.ram_wdata_o, tbl[i].wdata);
      chk($sformatf("tbl%0d_swap", i), swap, tbl[i].swap);
      chk($sformatf("tbl%0d_bank", i), bank, tbl[i].bank);
      chk($sformatf("tbl%0d_snap", i), snap, tbl[i].snap);
      chk($sformatf("tbl%0d_rv", i), bus.rd_valid_o, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rdata", i), bus.rd_data_o, tbl[i].rdata);
    end

    // CS held low: all-ones sweep completes into bank 1, then the FSM must park
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      keys = g; cs = 1'b0; bus.rd_req_i = 1'b0;
      #1;
      if (j < 8) begin
        chk("hold_we", bus.ram_we_o, 1);
        chk("hold_addr", bus.ram_addr_o, 9'h100 + j);
        chk("hold_wdata", bus.ram_wdata_o, (j == 7) ? 8'h1F : 8'hFF);
      end else begin
        chk("park_we", bus.ram_we_o, 0);
      end
      chk("hold_swap", swap, 0);
      chk("hold_bank", bank, 0);
    end
    @(negedge clk); cs = 1'b1; #1;
    chk("cs_rise_swap", swap, 1);
    chk("cs_rise_we", bus.ram_we_o, 0);
    @(negedge clk); bus.rd_req_i = 1'b1; bus.rd_addr_i = 8'h07; #1;
    chk("post_swap_bank", bank, 1);
    chk("post_swap_snap", snap, 3);
    chk("post_swap_pulse", swap, 0);
    @(negedge clk); bus.rd_addr_i = 8'h08; #1;
    chk("grp7_rv", bus.rd_valid_o, 1);
    chk("grp7_pad", bus.rd_data_o, 8'h1F);
    @(negedge clk); bus.rd_addr_i = 8'hFF; #1;
    chk("addr8_rv", bus.rd_valid_o, 1);
    chk("addr8_data", bus.rd_data_o, 8'h00);
    @(negedge clk); bus.rd_req_i = 1'b0; #1;
    chk("id_rv", bus.rd_valid_o, 1);
    chk("id_data", bus.rd_data_o, 8'h03);

    // async reset half a cycle after a RAM read is accepted
    @(negedge clk); bus.rd_req_i = 1'b1; bus.rd_addr_i = 8'h00;
    @(posedge clk); #1; rst = 1'b1; bus.rd_req_i = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_rv", bus.rd_valid_o, 0);
    chk("rst_mid_bank", bank, 0);
    chk("rst_mid_snap", snap, 0);
    chk("rst_mid_rdata", bus.rd_data_o, 0);

    // random traffic against the reference model
    m_cap = 1; m_fv = 0; m_bank = 0; m_rv = 0; m_left = 0;
    m_snapid = 0; m_rd = 0; m_snap = 0; m_front = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst = 1'b0;
      keys = {$urandom, $urandom};
      cs = ($urandom_range(0, 9) < 7);
      bus.rd_req_i = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      bus.rd_addr_i = (r < 8) ? 8'(r) : (r == 8) ? 8'hFF : 8'($urandom_range(8, 254));
      #1;
      hit = bus.rd_req_i && (bus.rd_addr_i < 8) && m_fv;
      exp_we = !m_cap && (m_left > 0) && !hit;
      exp_swap = !m_cap && (m_left == 0) && cs;
      chk("rnd_we", bus.ram_we_o, exp_we);
      if (hit) chk("rnd_rd_addr", bus.ram_addr_o, {m_bank, bus.rd_addr_i});
      if (exp_we) begin
        chk("rnd_wr_addr", bus.ram_addr_o, {~m_bank, 8'(8 - m_left)});
        chk("rnd_wdata", bus.ram_wdata_o, 8'(m_snap >> (8 * (8 - m_left))));
      end
      chk("rnd_swap", swap, exp_swap);
      chk("rnd_bank", bank, m_bank);
      chk("rnd_snap", snap, m_snapid);
      chk("rnd_rv", bus.rd_valid_o, m_rv);
      chk("rnd_rdata", bus.rd_data_o, m_rd);
      m_rv = bus.rd_req_i;
      if (bus.rd_req_i) begin
        if (bus.rd_addr_i < 8) m_rd = m_fv ? 8'(m_front >> (8 * bus.rd_addr_i)) : 8'h00;
        else if (bus.rd_addr_i == 8'hFF) m_rd = m_snapid;
        else m_rd = 8'h00;
      end
      if (m_cap) begin
        m_snap = {3'b000, keys};
        m_cap = 0;
        m_left = 8;
      end else if (m_left > 0) begin
        if (!hit) m_left--;
      end else if (cs) begin
        m_front = m_snap;
        m_bank = ~m_bank;
        m_snapid++;
        m_fv = 1;
        m_cap = 1;
      end
    end

    // 256 swaps wrap the snapshot id back to zero
    @(negedge clk); rst = 1'b1; bus.rd_req_i = 1'b0; cs = 1'b1;
    @(negedge clk); rst = 1'b0;
    nsw = 0; cyc = 0;
    while (nsw < 256 && cyc < 4000) begin
      #1;
      if (swap) nsw++;
      cyc++;
      @(negedge clk);
    end
    chk("wrap_swap_count", nsw, 256);
    #1;
    chk("wrap_snap", snap, 8'h00);
    chk("wrap_bank", bank, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
